// File: rtl/xor_checksum_stream_if.sv
// Valid/ready bus for xor_checksum_stream: upstream word channel plus downstream result channel.
// When XOR_CSUM_PARITY_EN is defined the result channel also carries down_parity.
interface xor_checksum_stream_if #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 5
);
   logic             up_valid;
   logic             up_ready;
   logic [WIDTH-1:0] up_data;
   logic             up_last;
   logic             down_valid;
   logic             down_ready;
   logic [WIDTH-1:0] down_data;
   logic [LEN_W-1:0] down_len;
   logic             down_overflow;
`ifdef XOR_CSUM_PARITY_EN
   logic             down_parity;

   modport master (
      output up_valid, up_data, up_last, down_ready,
      input  up_ready, down_valid, down_data, down_len, down_overflow, down_parity
   );

   modport slave (
      input  up_valid, up_data, up_last, down_ready,
      output up_ready, down_valid, down_data, down_len, down_overflow, down_parity
   );
`else
   modport master (
      output up_valid, up_data, up_last, down_ready,
      input  up_ready, down_valid, down_data, down_len, down_overflow
   );

   modport slave (
      input  up_valid, up_data, up_last, down_ready,
      output up_ready, down_valid, down_data, down_len, down_overflow
   );
`endif
endinterface

// File: rtl/xor_checksum_stream.sv
// Streaming XOR checksum: folds a packet of words into checksum, length and overflow flag.
// Optional macro XOR_CSUM_PARITY_EN adds down_parity (reduction XOR of the closing checksum).

module xor_checksum_mux2 (
   input  logic sel,
   input  logic a0,
   input  logic a1,
   output logic y
);
   assign y = sel ? a1 : a0;
endmodule

module xor_checksum_stream #(
   parameter int               WIDTH     = 8,
   parameter int               MAX_WORDS = 16,
   parameter logic [WIDTH-1:0] INIT      = '0,
   localparam int              LEN_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   xor_checksum_stream_if.slave  bus
);

   logic [WIDTH-1:0] acc_q,  acc_d;
   logic [LEN_W-1:0] cnt_q,  cnt_d;
   logic             first_q, first_d;
   logic             down_valid_q, down_valid_d;
   logic [WIDTH-1:0] down_data_q,  down_data_d;
   logic [LEN_W-1:0] down_len_q,   down_len_d;
   logic             down_ovf_q,   down_ovf_d;

   logic             up_ready;
   logic             accept;
   logic             pop;
   logic             close;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] sum;
   logic [LEN_W-1:0] cnt_base;
   logic [LEN_W-1:0] cnt_next;

   // A pending result blocks upstream unless it is being consumed this cycle.
   assign up_ready = !down_valid_q || bus.down_ready;
   assign accept   = bus.up_valid && up_ready;
   assign pop      = down_valid_q && bus.down_ready;

   assign base     = first_q ? INIT : acc_q;
   assign cnt_base = first_q ? '0 : cnt_q;
   assign cnt_next = cnt_base + LEN_W'(1);
   assign close    = bus.up_last || (cnt_next == LEN_W'(MAX_WORDS));

   // Each checksum bit toggles when the incoming data bit is set.
   for (genvar i = 0; i < WIDTH; i++) begin : g_sum
      xor_checksum_mux2 u_mux (
         .sel (bus.up_data[i]),
         .a0  (base[i]),
         .a1  (~base[i]),
         .y   (sum[i])
      );
   end

`ifdef XOR_CSUM_PARITY_EN
   logic [WIDTH:0] par_chain;
   logic           down_par_q, down_par_d;

   assign par_chain[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_par
      xor_checksum_mux2 u_mux (
         .sel (sum[i]),
         .a0  (par_chain[i]),
         .a1  (~par_chain[i]),
         .y   (par_chain[i+1])
      );
   end
`endif

   always_comb begin
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      first_d      = first_q;
      down_valid_d = down_valid_q;
      down_data_d  = down_data_q;
      down_len_d   = down_len_q;
      down_ovf_d   = down_ovf_q;
`ifdef XOR_CSUM_PARITY_EN
      down_par_d   = down_par_q;
`endif

      if (pop) begin
         down_valid_d = 1'b0;
      end

      if (accept) begin
         if (close) begin
            down_valid_d = 1'b1;
            down_data_d  = sum;
            down_len_d   = cnt_next;
            down_ovf_d   = !bus.up_last;
            first_d      = 1'b1;
`ifdef XOR_CSUM_PARITY_EN
            down_par_d   = par_chain[WIDTH];
`endif
         end else begin
            acc_d   = sum;
            cnt_d   = cnt_next;
            first_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q        <= INIT;
         cnt_q        <= '0;
         first_q      <= 1'b1;
         down_valid_q <= 1'b0;
         down_data_q  <= '0;
         down_len_q   <= '0;
         down_ovf_q   <= 1'b0;
`ifdef XOR_CSUM_PARITY_EN
         down_par_q   <= 1'b0;
`endif
      end else begin
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         first_q      <= first_d;
         down_valid_q <= down_valid_d;
         down_data_q  <= down_data_d;
         down_len_q   <= down_len_d;
         down_ovf_q   <= down_ovf_d;
`ifdef XOR_CSUM_PARITY_EN
         down_par_q   <= down_par_d;
`endif
      end
   end

   assign bus.up_ready      = up_ready;
   assign bus.down_valid    = down_valid_q;
   assign bus.down_data     = down_data_q;
   assign bus.down_len      = down_len_q;
   assign bus.down_overflow = down_ovf_q;
`ifdef XOR_CSUM_PARITY_EN
   assign bus.down_parity   = down_par_q;
`endif

endmodule

// File: tb/tb_xor_checksum_stream.sv
// Directed bench for xor_checksum_stream (WIDTH=8, MAX_WORDS=4); a second instance seeded with INIT=0xFF.
// Parity checks are included when XOR_CSUM_PARITY_EN is defined.
module tb_xor_checksum_stream;

   localparam int WIDTH = 8;
   localparam int MAXW  = 4;
   localparam int LEN_W = $clog2(MAXW + 1);

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   xor_checksum_stream_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();
   xor_checksum_stream_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus_ff ();

   xor_checksum_stream #(.WIDTH(WIDTH), .MAX_WORDS(MAXW), .INIT(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   xor_checksum_stream #(.WIDTH(WIDTH), .MAX_WORDS(MAXW), .INIT(8'hFF)) dut_ff (
      .clk (clk),
      .rst (rst),
      .bus (bus_ff.slave)
   );

   assign bus_ff.up_valid   = bus.up_valid;
   assign bus_ff.up_data    = bus.up_data;
   assign bus_ff.up_last    = bus.up_last;
   assign bus_ff.down_ready = bus.down_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic word(input logic [7:0] d, input logic last);
      bus.up_valid = 1'b1;
      bus.up_data  = d;
      bus.up_last  = last;
      tick();
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      rst            = 1'b1;
      bus.up_valid   = 1'b0;
      bus.up_data    = '0;
      bus.up_last    = 1'b0;
      bus.down_ready = 1'b1;

      // 1. reset
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_valid", 32'(bus.down_valid), 32'd0);
      chk("rst_data",  32'(bus.down_data),  32'h00);
      chk("rst_len",   32'(bus.down_len),   32'd0);
      chk("rst_ovf",   32'(bus.down_overflow), 32'd0);
      chk("rst_ready", 32'(bus.up_ready),   32'd1);

      // 2. basic packet 5A ^ 3C ^ FF = 99
      word(8'h5A, 1'b0);
      chk("basic_nopartial", 32'(bus.down_valid), 32'd0);
      word(8'h3C, 1'b0);
      word(8'hFF, 1'b1);
      bus.up_valid = 1'b0;
      chk("basic_valid", 32'(bus.down_valid), 32'd1);
      chk("basic_data",  32'(bus.down_data),  32'h99);
      chk("basic_len",   32'(bus.down_len),   32'd3);
      chk("basic_ovf",   32'(bus.down_overflow), 32'd0);
`ifdef XOR_CSUM_PARITY_EN
      chk("basic_par",   32'(bus.down_parity), 32'd0);
`endif
      tick();
      chk("basic_drop",  32'(bus.down_valid), 32'd0);
      chk("basic_keep",  32'(bus.down_data),  32'h99);
      tick();
      chk("idle_keep",   32'(bus.down_data),  32'h99);

      // 3. backpressure
      bus.down_ready = 1'b0;
      word(8'h81, 1'b1);
      bus.up_data = 8'h42;
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", 32'(bus.down_valid), 32'd1);
         chk("bp_data",  32'(bus.down_data),  32'h81);
         chk("bp_len",   32'(bus.down_len),   32'd1);
         chk("bp_ready", 32'(bus.up_ready),   32'd0);
         tick();
      end
      bus.down_ready = 1'b1;
      #1;
      chk("bp_ready_comb", 32'(bus.up_ready), 32'd1);
      tick();
      bus.up_valid = 1'b0;
      chk("bp2_valid", 32'(bus.down_valid), 32'd1);
      chk("bp2_data",  32'(bus.down_data),  32'h42);
      chk("bp2_len",   32'(bus.down_len),   32'd1);
      chk("bp2_ovf",   32'(bus.down_overflow), 32'd0);
      tick();
      chk("bp2_drop",  32'(bus.down_valid), 32'd0);

      // 4. overflow at MAX_WORDS
      word(8'h01, 1'b0);
      word(8'h02, 1'b0);
      word(8'h04, 1'b0);
      word(8'h08, 1'b0);
      chk("ovf1_valid", 32'(bus.down_valid), 32'd1);
      chk("ovf1_data",  32'(bus.down_data),  32'h0F);
      chk("ovf1_len",   32'(bus.down_len),   32'd4);
      chk("ovf1_ovf",   32'(bus.down_overflow), 32'd1);
`ifdef XOR_CSUM_PARITY_EN
      chk("ovf1_par",   32'(bus.down_parity), 32'd0);
`endif
      word(8'h10, 1'b1);
      bus.up_valid = 1'b0;
      chk("ovf2_valid", 32'(bus.down_valid), 32'd1);
      chk("ovf2_data",  32'(bus.down_data),  32'h10);
      chk("ovf2_len",   32'(bus.down_len),   32'd1);
      chk("ovf2_ovf",   32'(bus.down_overflow), 32'd0);
`ifdef XOR_CSUM_PARITY_EN
      chk("ovf2_par",   32'(bus.down_parity), 32'd1);
`endif
      tick();

      // 5. reset mid-packet
      word(8'h11, 1'b0);
      word(8'h22, 1'b0);
      bus.up_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_valid", 32'(bus.down_valid), 32'd0);
      chk("mid_data",  32'(bus.down_data),  32'h00);
      word(8'hAA, 1'b1);
      bus.up_valid = 1'b0;
      chk("mid2_valid", 32'(bus.down_valid), 32'd1);
      chk("mid2_data",  32'(bus.down_data),  32'hAA);
      chk("mid2_len",   32'(bus.down_len),   32'd1);
      chk("init_data",  32'(bus_ff.down_data), 32'h55);
      chk("init_len",   32'(bus_ff.down_len),  32'd1);
      tick();
      chk("mid2_drop",  32'(bus.down_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xor_checksum_stream.md
Name: xor_checksum_stream

Overview:
- Streaming XOR checksum accumulator. Folds a packet of WIDTH-bit words into one WIDTH-bit checksum, a word count, and an overflow flag.
- Per-bit XOR datapath is built only from 2:1 mux instances: bit_next = data_bit ? ~acc_bit : acc_bit. No ^ operator in the datapath.
- Sits between a valid/ready word source and a valid/ready consumer. It is the parametrised, sequential successor of the single-bit mux-built XOR gate.

Parameters:
- WIDTH, 8, data word and checksum width (>=1).
- MAX_WORDS, 16, maximum words per packet before forced close (>=1).
- INIT, 0, WIDTH-bit seed loaded into the accumulator at the start of every packet.
- LEN_W, $clog2(MAX_WORDS+1), derived width of the length field. Not for override.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- up_valid  input  1  upstream word valid
- up_ready  output  1  block can accept a word
- up_data  input  WIDTH  data word
- up_last  input  1  word is the last of its packet
- down_valid  output  1  checksum result valid
- down_ready  input  1  consumer accepts the result
- down_data  output  WIDTH  packet checksum
- down_len  output  LEN_W  words in the packet
- down_overflow  output  1  packet was force-closed at MAX_WORDS

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high, sampled on the rising clk edge.
- Reset values: down_valid=0, down_data=0, down_len=0, down_overflow=0. Accumulator=INIT, word counter=0, first-word flag=1. up_ready=1 in the first cycle after reset deasserts.
- Handshakes:
  - Upstream transfer when up_valid && up_ready.
  - Downstream transfer when down_valid && down_ready.
- up_ready = !down_valid || down_ready. This is combinational from down_ready; no other comb path from input to output.
- Per accepted word:
  - base = first ? INIT : acc
  - sum = base XOR up_data, through the mux datapath
  - cnt_next = (first ? 0 : cnt) + 1
- Close condition: up_last || cnt_next == MAX_WORDS.
  - On close: down_data<=sum, down_len<=cnt_next, down_overflow<=(!up_last), down_valid<=1. Then first<=1.
  - Otherwise: acc<=sum, cnt<=cnt_next, first<=0.
- Latency: result is visible the cycle after the closing word is accepted.
- Result hold: down_* stay stable while down_valid && !down_ready. up_ready=0 during that time, so no words are lost and the partial accumulator is held.
- Simultaneous pop and close in one cycle: down_valid stays 1 and the new result replaces the old one. Back-to-back packets therefore sustain one word per cycle.
- Pop without a new close: down_valid<=0. down_data/len/overflow keep their last values.
- An idle cycle (up_valid=0) changes no state.
- Reset mid-packet discards the partial accumulator and any pending result. The next accepted word starts a fresh packet.
- A 1-word packet with up_last=1 gives down_data=INIT^word, down_len=1.
- With MAX_WORDS=1, every word closes; down_overflow=!up_last.

Optional Feature:
- Macro: XOR_CSUM_PARITY_EN.
- Defined: adds output down_parity (1 bit), the reduction XOR of the closing sum. It is built from a chain of mux-based XORs, registered alongside down_data, reset to 0, and held while down_valid && !down_ready.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=8, MAX_WORDS=4, INIT=0 unless noted.
1. Reset: rst=1 for 2 cycles, then 0 -> down_valid=0, down_data=0x00, down_len=0, down_overflow=0, up_ready=1.
2. Basic packet: words 0x5A, 0x3C, 0xFF(last) on consecutive cycles, down_ready=1 -> the next cycle down_valid=1, down_data=0x99, down_len=3, down_overflow=0; down_valid drops one cycle later.
3. Backpressure: word 0x81(last), down_ready=0 for 3 cycles -> down_valid=1, down_data=0x81, down_len=1, up_ready=0 and all outputs stable. Then down_ready=1 together with up_valid and word 0x42(last) -> both accepted that cycle; next result is 0x42, down_len=1.
4. Overflow: words 0x01, 0x02, 0x04, 0x08, 0x10 with up_last only on 0x10 -> first result 0x0F, down_len=4, down_overflow=1; second result 0x10, down_len=1, down_overflow=0.
5. Reset mid-packet: accept 0x11 and 0x22 (no last), pulse rst for 1 cycle, then 0xAA(last) -> down_data=0xAA, down_len=1, with no result emitted for the aborted words. With INIT=0xFF, the same 0xAA(last) gives down_data=0x55.
6. Parity, with XOR_CSUM_PARITY_EN defined -> down_parity=0 for 0x99, 0 for 0x0F, 1 for 0x10. The bench also compiles with the macro undefined and scenarios 1-5 must pass unchanged.
